// File: rtl/vga_sync_monitor.sv
// VGA timing monitor: locks onto incoming h/v sync, tracks pixel/line position,
// and raises sticky flags for period, width and blanking-colour violations.
module vga_sync_monitor #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en_i,
    input  logic               h_sync_i,
    input  logic               v_sync_i,
    input  logic [COLOR_W-1:0] red_i,
    input  logic [COLOR_W-1:0] green_i,
    input  logic [COLOR_W-1:0] blue_i,
    input  logic               clear_i,
    output logic               locked_o,
    output logic [FRAME_W-1:0] frame_cnt_o,
    output logic               err_hper_o,
    output logic               err_hwid_o,
    output logic               err_vper_o,
    output logic               err_vwid_o,
    output logic               err_blank_o,
    output logic               err_any_o
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCNT_W   = $clog2(H_TOTAL + 1);
    localparam int unsigned VCNT_W   = $clog2(V_TOTAL + 1);
    localparam int unsigned H_ACT_LO = H_SYNC + H_BP;
    localparam int unsigned H_ACT_HI = H_SYNC + H_BP + H_ACTIVE;
    localparam int unsigned V_ACT_LO = V_SYNC + V_BP;
    localparam int unsigned V_ACT_HI = V_SYNC + V_BP + V_ACTIVE;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_HSEEN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
    logic                h_prev_q, h_prev_d;
    logic                v_prev_q, v_prev_d;
    logic                v_hedge_q, v_hedge_d;
    logic                locked_q, locked_d;
    logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic                err_hper_q, err_hper_d;
    logic                err_hwid_q, err_hwid_d;
    logic                err_vper_q, err_vper_d;
    logic                err_vwid_q, err_vwid_d;
    logic                err_blank_q, err_blank_d;
    logic                err_any_q, err_any_d;

    logic h_asrt, v_asrt;
    logic h_rise, h_fall, v_rise, v_fall;
    logic in_lock, h_in, v_in, color_nz;
    logic hper_det, hwid_det, vper_det, vwid_det, blank_det, frame_inc;

    // Normalised sync levels and edges, qualified by the pixel strobe
    always_comb begin
        h_asrt = (h_sync_i == SYNC_POL);
        v_asrt = (v_sync_i == SYNC_POL);
        h_rise = pix_en_i &  h_asrt & ~h_prev_q;
        h_fall = pix_en_i & ~h_asrt &  h_prev_q;
        v_rise = pix_en_i &  v_asrt & ~v_prev_q;
        v_fall = pix_en_i & ~v_asrt &  v_prev_q;
    end

    // Position counters; vcnt only advances at line starts
    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        h_prev_d  = h_prev_q;
        v_prev_d  = v_prev_q;
        v_hedge_d = v_hedge_q;
        if (pix_en_i) begin
            h_prev_d = h_asrt;
            v_prev_d = v_asrt;
            if (h_rise) begin
                hcnt_d = '0;
            end else if (hcnt_q != HCNT_W'(H_TOTAL)) begin
                hcnt_d = hcnt_q + HCNT_W'(1);
            end
            if (h_rise) begin
                v_hedge_d = v_asrt;
                if (v_asrt && !v_hedge_q) begin
                    vcnt_d = '0;
                end else if (vcnt_q != VCNT_W'(V_TOTAL)) begin
                    vcnt_d = vcnt_q + VCNT_W'(1);
                end
            end
        end
    end

    // Violation detectors; position checks use the current sample's coordinates
    always_comb begin
        in_lock   = (state_q == ST_LOCKED);
        h_in      = (hcnt_d >= HCNT_W'(H_ACT_LO)) && (hcnt_d < HCNT_W'(H_ACT_HI));
        v_in      = (vcnt_d >= VCNT_W'(V_ACT_LO)) && (vcnt_d < VCNT_W'(V_ACT_HI));
        color_nz  = (|red_i) | (|green_i) | (|blue_i);
        hper_det  = in_lock & h_rise & (hcnt_q != HCNT_W'(H_TOTAL - 1));
        hwid_det  = in_lock & h_fall & (hcnt_d != HCNT_W'(H_SYNC));
        vper_det  = in_lock & v_rise & (vcnt_q != VCNT_W'(V_TOTAL - 1));
        vwid_det  = in_lock & v_fall & (vcnt_d != VCNT_W'(V_SYNC));
        blank_det = in_lock & pix_en_i & color_nz & ~(h_in & v_in);
        frame_inc = in_lock & v_rise & ~hper_det & ~vper_det;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: if (h_rise)          state_d = ST_HSEEN;
            ST_HSEEN:  if (h_rise & v_rise) state_d = ST_LOCKED;
            ST_LOCKED: if (hper_det | vper_det) state_d = ST_SEARCH;
            default:                        state_d = ST_SEARCH;
        endcase
    end

    // FSM outputs: a new error in the clearing sample still lands in the flag
    always_comb begin
        locked_d    = (state_d == ST_LOCKED);
        frame_cnt_d = frame_cnt_q;
        err_hper_d  = err_hper_q;
        err_hwid_d  = err_hwid_q;
        err_vper_d  = err_vper_q;
        err_vwid_d  = err_vwid_q;
        err_blank_d = err_blank_q;
        if (pix_en_i && clear_i) begin
            frame_cnt_d = '0;
            err_hper_d  = 1'b0;
            err_hwid_d  = 1'b0;
            err_vper_d  = 1'b0;
            err_vwid_d  = 1'b0;
            err_blank_d = 1'b0;
        end else if (frame_inc) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
        err_hper_d  = err_hper_d  | hper_det;
        err_hwid_d  = err_hwid_d  | hwid_det;
        err_vper_d  = err_vper_d  | vper_det;
        err_vwid_d  = err_vwid_d  | vwid_det;
        err_blank_d = err_blank_d | blank_det;
        err_any_d   = err_hper_d | err_hwid_d | err_vper_d | err_vwid_d | err_blank_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            h_prev_q    <= 1'b0;
            v_prev_q    <= 1'b0;
            v_hedge_q   <= 1'b0;
            locked_q    <= 1'b0;
            frame_cnt_q <= '0;
            err_hper_q  <= 1'b0;
            err_hwid_q  <= 1'b0;
            err_vper_q  <= 1'b0;
            err_vwid_q  <= 1'b0;
            err_blank_q <= 1'b0;
            err_any_q   <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            h_prev_q    <= h_prev_d;
            v_prev_q    <= v_prev_d;
            v_hedge_q   <= v_hedge_d;
            locked_q    <= locked_d;
            frame_cnt_q <= frame_cnt_d;
            err_hper_q  <= err_hper_d;
            err_hwid_q  <= err_hwid_d;
            err_vper_q  <= err_vper_d;
            err_vwid_q  <= err_vwid_d;
            err_blank_q <= err_blank_d;
            err_any_q   <= err_any_d;
        end
    end

    assign locked_o    = locked_q;
    assign frame_cnt_o = frame_cnt_q;
    assign err_hper_o  = err_hper_q;
    assign err_hwid_o  = err_hwid_q;
    assign err_vper_o  = err_vper_q;
    assign err_vwid_o  = err_vwid_q;
    assign err_blank_o = err_blank_q;
    assign err_any_o   = err_any_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a tiny 16x8 raster, pixel strobe every 2nd clock.
module tb_vga_sync_monitor;

    localparam int H_ACT = 8, H_FP = 2, H_SY = 4, H_BP = 2;
    localparam int V_ACT = 4, V_FP = 1, V_SY = 2, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int HLO = H_SY + H_BP, HHI = H_SY + H_BP + H_ACT;
    localparam int VLO = V_SY + V_BP, VHI = V_SY + V_BP + V_ACT;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_en = 1'b0;
    logic          h_sync = 1'b1;
    logic          v_sync = 1'b1;
    logic [3:0]    red = '0, green = '0, blue = '0;
    logic          clear = 1'b0;
    logic          locked;
    logic [FW-1:0] frame_cnt;
    logic          err_hper, err_hwid, err_vper, err_vwid, err_blank, err_any;

    int n_checks = 0;
    int n_fail = 0;

    vga_sync_monitor #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .SYNC_POL(1'b0), .COLOR_W(4), .FRAME_W(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en_i(pix_en),
        .h_sync_i(h_sync), .v_sync_i(v_sync),
        .red_i(red), .green_i(green), .blue_i(blue), .clear_i(clear),
        .locked_o(locked), .frame_cnt_o(frame_cnt),
        .err_hper_o(err_hper), .err_hwid_o(err_hwid), .err_vper_o(err_vper),
        .err_vwid_o(err_vwid), .err_blank_o(err_blank), .err_any_o(err_any)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          v;
        int          h;
        logic [11:0] rgb;
        logic        exp_blank;
    } blank_vec_t;

    blank_vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One strobed sample, then an idle clock carrying junk that must be ignored
    task automatic send_pix(input logic ha, input logic va, input logic [11:0] rgb, input logic clr);
        @(negedge clk);
        pix_en = 1'b1;
        h_sync = ~ha;
        v_sync = ~va;
        {red, green, blue} = rgb;
        clear = clr;
        @(negedge clk);
        pix_en = 1'b0;
        h_sync = ha;
        v_sync = va;
        {red, green, blue} = 12'hFFF;
        clear = 1'b0;
    endtask

    task automatic send_line(input int v, input int h0, input int h1, input int hsw, input int vsw,
                             input int inj_h, input logic [11:0] inj_rgb, input int clr_h);
        for (int h = h0; h < h1; h++) begin
            logic [11:0] rgb;
            rgb = (h >= HLO && h < HHI && v >= VLO && v < VHI) ? 12'h359 : 12'h000;
            if (h == inj_h) rgb = inj_rgb;
            send_pix(h < hsw, v < vsw, rgb, h == clr_h);
        end
    endtask

    task automatic send_frame(input int nlines, input int vsw, input int inj_v, input int inj_h,
                              input logic [11:0] inj_rgb, input int clr_v, input int clr_h,
                              input int long_v, input int hsw_v);
        for (int v = 0; v < nlines; v++)
            send_line(v, 0, (v == long_v) ? H_TOT + 1 : H_TOT, (v == hsw_v) ? H_SY - 1 : H_SY, vsw,
                      (v == inj_v) ? inj_h : -1, inj_rgb, (v == clr_v) ? clr_h : -1);
    endtask

    task automatic clean_frame();
        send_frame(V_TOT, V_SY, -1, -1, 12'h000, -1, -1, -1, -1);
    endtask

    task automatic clear_frame();
        send_frame(V_TOT, V_SY, -1, -1, 12'h000, V_TOT - 1, H_TOT - 1, -1, -1);
    endtask

    initial begin
        vecs[0]  = '{0, 0, 12'h100, 1'b1};
        vecs[1]  = '{3, 6, 12'h100, 1'b0};
        vecs[2]  = '{3, 5, 12'h100, 1'b1};
        vecs[3]  = '{3, 13, 12'h100, 1'b0};
        vecs[4]  = '{3, 14, 12'h100, 1'b1};
        vecs[5]  = '{2, 8, 12'h100, 1'b1};
        vecs[6]  = '{6, 13, 12'h010, 1'b0};
        vecs[7]  = '{7, 8, 12'h100, 1'b1};
        vecs[8]  = '{6, 15, 12'h100, 1'b1};
        vecs[9]  = '{4, 2, 12'h001, 1'b1};
        vecs[10] = '{4, 2, 12'h000, 1'b0};
        vecs[11] = '{5, 10, 12'h0F0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_locked", locked, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_any", err_any, 0);
        check("rst_err_blank", err_blank, 0);
        rst_n = 1'b1;

        // Acquisition: last line of a prior frame, then 5 clean frames
        send_line(V_TOT - 1, 0, H_TOT, H_SY, V_SY, -1, 12'h000, -1);
        check("acq_hseen_not_locked", locked, 0);
        clean_frame();
        check("acq_locked_frame0", locked, 1);
        check("acq_frame_cnt0", frame_cnt, 0);
        repeat (4) clean_frame();
        check("clean_locked", locked, 1);
        check("clean_frame_cnt", frame_cnt, 4);
        check("clean_err_any", err_any, 0);

        // Frame counter wraps at 2^FW
        repeat (5) clean_frame();
        check("wrap_frame_cnt", frame_cnt, (4 + 5) % (1 << FW));

        // Blanking window boundaries, each followed by a clearing frame
        for (int i = 0; i < 12; i++) begin
            send_frame(V_TOT, V_SY, vecs[i].v, vecs[i].h, vecs[i].rgb, -1, -1, -1, -1);
            check($sformatf("blank_vec%0d", i), err_blank, vecs[i].exp_blank);
            check($sformatf("blank_vec%0d_locked", i), locked, 1);
            clear_frame();
            check($sformatf("blank_vec%0d_cleared", i), err_any, 0);
        end
        check("blank_clear_frame_cnt", frame_cnt, 0);

        // Clear coincident with a blanking error
        send_frame(V_TOT, V_SY, 1, 3, 12'h100, 1, 3, -1, -1);
        check("clr_coinc_err_blank", err_blank, 1);
        check("clr_coinc_frame_cnt", frame_cnt, 0);
        clear_frame();
        check("clr_alone_hper", err_hper, 0);
        check("clr_alone_hwid", err_hwid, 0);
        check("clr_alone_vper", err_vper, 0);
        check("clr_alone_vwid", err_vwid, 0);
        check("clr_alone_blank", err_blank, 0);
        check("clr_alone_any", err_any, 0);

        // Short h_sync pulse
        send_frame(V_TOT, V_SY, -1, -1, 12'h000, -1, -1, -1, 2);
        check("hwid_err", err_hwid, 1);
        check("hwid_locked", locked, 1);
        check("hwid_no_hper", err_hper, 0);
        check("hwid_err_any", err_any, 1);
        clear_frame();

        // Short v_sync pulse
        send_frame(V_TOT, 1, -1, -1, 12'h000, -1, -1, -1, -1);
        check("vwid_err", err_vwid, 1);
        check("vwid_locked", locked, 1);
        check("vwid_no_vper", err_vper, 0);
        clear_frame();

        // One 17-pixel line: lose lock, relock without counting the broken frame
        send_frame(V_TOT, V_SY, -1, -1, 12'h000, -1, -1, 3, -1);
        check("hper_err", err_hper, 1);
        check("hper_unlocked", locked, 0);
        check("hper_frame_cnt", frame_cnt, 1);
        clean_frame();
        check("hper_relocked", locked, 1);
        check("hper_relock_no_inc", frame_cnt, 1);
        clean_frame();
        check("hper_next_inc", frame_cnt, 2);
        clear_frame();

        // One 9-line frame
        send_frame(V_TOT + 1, V_SY, -1, -1, 12'h000, -1, -1, -1, -1);
        send_line(0, 0, H_TOT, H_SY, V_SY, -1, 12'h000, -1);
        check("vper_err", err_vper, 1);
        check("vper_unlocked", locked, 0);
        check("vper_no_inc", frame_cnt, 1);
        check("vper_no_hper", err_hper, 0);
        for (int v = 1; v < V_TOT; v++) send_line(v, 0, H_TOT, H_SY, V_SY, -1, 12'h000, -1);
        clean_frame();
        check("vper_relocked", locked, 1);
        clear_frame();

        // Reset mid-line inside the v_sync pulse while locked
        send_line(0, 0, H_TOT, H_SY, V_SY, 2, 12'h001, -1);
        send_line(1, 0, 8, H_SY, V_SY, -1, 12'h000, -1);
        check("prerst_err_blank", err_blank, 1);
        check("prerst_frame_cnt", frame_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_locked", locked, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_err_blank", err_blank, 0);
        check("midrst_err_any", err_any, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_line(1, 8, H_TOT, H_SY, V_SY, -1, 12'h000, -1);
        for (int v = 2; v < V_TOT; v++) send_line(v, 0, H_TOT, H_SY, V_SY, -1, 12'h000, -1);
        check("rst_not_locked_1st_vedge", locked, 0);
        send_line(0, 0, H_TOT, H_SY, V_SY, -1, 12'h000, -1);
        check("rst_relock_2nd_vedge", locked, 1);
        check("rst_relock_frame_cnt", frame_cnt, 0);
        for (int v = 1; v < V_TOT; v++) send_line(v, 0, H_TOT, H_SY, V_SY, -1, 12'h000, -1);
        clean_frame();
        check("rst_after_frame_cnt", frame_cnt, 1);
        check("rst_after_err_any", err_any, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
